fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I core: holds the program counter, fetches one instruction word per step from instruction memory over a req/ack handshake, and presents it on `instr` to the decoder and immediate extender. It also produces the next PC for the following fetch. Sources are PC+4, the branch/JAL target PC+ImmExt formed from the immediate extender's output, and the JALR target taken from the ALU.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request; address valid while high.
- `imem_addr` out 32: fetch address, equal to `PC`.
- `imem_ack` in 1: memory has data on `imem_rdata` this cycle; only sampled while `imem_req`=1.
- `imem_rdata` in 32: instruction word.
- `retire` in 1: core has finished with the current instruction; advance PC.
- `stall` in 1: suppresses `retire`.
- `PCSrc` in 2: next-PC select.
  - 00: PC+4
  - 01: PCTarget
  - 10: JALR
  - 11: PC+4
- `ImmExt` in 32: sign-extended immediate of the current instruction.
- `ALUResult` in 32: JALR target before LSB clear.
- `instr` out 32: registered instruction word.
- `instr_valid` out 1: `instr` belongs to `PC` and may be executed.
- `PC` out 32: address of `instr`.
- `PCPlus4` out 32: PC+4.
- `PCTarget` out 32: PC+ImmExt.
- `misaligned` out 1: sticky instruction-address-misaligned flag.

## Operation
- States: FETCH, HOLD, TRAP.
- Reset (`rst`=1 at edge) loads the following; overrides every other input, in any state:
  - state=FETCH
  - `PC`=RESET_PC
  - `instr`=32'h0000_0013 (NOP)
  - `instr_valid`=0
  - `misaligned`=0
- FETCH:
  - `imem_req`=1, `imem_addr`=`PC`.
  - On `imem_ack`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, go to HOLD.
  - Otherwise remain in FETCH; any number of wait cycles is allowed.
  - `retire` is ignored in FETCH.
- HOLD:
  - `imem_req`=0.
  - On `retire`=1 and `stall`=0: compute next PC from `PCSrc`, `instr_valid`<=0.
    - If next[1:0]==0: `PC`<=next, go to FETCH.
    - Else: go to TRAP, `misaligned`<=1, `PC` unchanged.
  - `retire` with `stall`=1 is ignored; `instr` and `PC` are held.
- TRAP:
  - `imem_req`=0, `instr_valid`=0, `misaligned`=1.
  - Exit only by reset.
- Arithmetic (all 32-bit modulo 2^32, wrap-around is silent):
  - `PCPlus4` = PC+4.
  - `PCTarget` = PC+ImmExt.
  - JALR next = {ALUResult[31:1],1'b0}.
- Misalignment check is on bits [1:0] after the JALR LSB clear. Example: ALUResult=0x103 → 0x102 → trap.
- `PCPlus4` and `PCTarget` are combinational from `PC` and `ImmExt`; valid in every state.
- `imem_ack` while `imem_req`=0 is ignored.

## Timing
- First `imem_req`: the first cycle with `rst`=0.
- Fetch latency: `instr_valid` rises on the edge at which `imem_ack`=1 is sampled.
- Minimum step is 2 cycles per instruction: ack in cycle N, retire in cycle N+1, new req in cycle N+2.
- `imem_addr` is stable for the whole request; it changes only on a HOLD→FETCH transition or on reset.
- Reset asserted mid-fetch: the request is dropped. `imem_req` is 0 on the cycle after reset, then re-issues at RESET_PC.
- `retire` and `rst` in the same cycle: reset wins.

## Test plan
- Reset release, ack in first req cycle, `imem_rdata`=0x00500093:
  - `imem_addr`=0x0.
  - `instr`=0x00500093 and `instr_valid`=1 on the next cycle.
  - After retire with PCSrc=00, `PC`=0x4.
- Wait states: ack withheld for 3 cycles → `imem_req` held high 4 cycles, `imem_addr` constant, `instr_valid` stays 0 until the ack edge.
- Branch, PC=0x20, ImmExt=0xFFFFFFF0, PCSrc=01 → `PCTarget`=0x10, next `imem_addr`=0x10.
- JALR, ALUResult=0x201, PCSrc=10 → PC=0x200.
- Same setup with ALUResult=0x102 → TRAP, `misaligned`=1, no further `imem_req` until reset.
- Retire held with `stall`=1 for 2 cycles → `PC`/`instr` unchanged. Stall drop with retire → advance.
- Wrap: RESET_PC=0xFFFFFFFC, PCSrc=00 → next PC=0x0.
- Reset asserted during wait-state fetch → `imem_req`=0 one cycle, then re-fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the RV32I core: owns the PC, fetches one word per
// step over a req/ack handshake and selects the next PC once the word retires.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        retire,
   input  logic        stall,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] ImmExt,
   input  logic [31:0] ALUResult,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] PCTarget,
   output logic        misaligned
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_TRAP  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;

   logic [31:0] pc_plus4_s;
   logic [31:0] pc_target_s;
   logic [31:0] jalr_target_s;
   logic [31:0] next_pc_s;

   function automatic logic is_word_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction

   assign pc_plus4_s    = pc_q + 32'd4;
   assign pc_target_s   = pc_q + ImmExt;
   // JALR always lands on an even address; bit 1 is left for the alignment check.
   assign jalr_target_s = ALUResult & 32'hFFFF_FFFE;

   // Next-PC source select.
   always_comb begin
      next_pc_s = pc_plus4_s;
      case (PCSrc)
         2'b00:   next_pc_s = pc_plus4_s;
         2'b01:   next_pc_s = pc_target_s;
         2'b10:   next_pc_s = jalr_target_s;
         default: next_pc_s = pc_plus4_s;
      endcase
   end

   // Fetch/hold/trap sequencing and next values of all architectural state.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      mis_d   = mis_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (retire && !stall) begin
               valid_d = 1'b0;
               if (is_word_aligned(next_pc_s[1:0])) begin
                  pc_d    = next_pc_s;
                  state_d = ST_FETCH;
               end else begin
                  mis_d   = 1'b1;
                  state_d = ST_TRAP;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_TRAP: begin
            valid_d = 1'b0;
            mis_d   = 1'b1;
            state_d = ST_TRAP;
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_FETCH;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   // A request in flight is dropped for the reset cycle itself.
   assign imem_req    = (state_q == ST_FETCH) && !rst;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign PC          = pc_q;
   assign PCPlus4     = pc_plus4_s;
   assign PCTarget    = pc_target_s;
   assign misaligned  = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a step-level reference model checked every
// cycle, plus literal expectations from the fetch scenarios.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC_A = 32'h0000_0000;
   localparam logic [31:0] RST_PC_B = 32'hFFFF_FFFC;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, imem_ack, retire, stall;
   logic [31:0] imem_rdata, ImmExt, ALUResult;
   logic [1:0]  PCSrc;

   logic        a_req, a_valid, a_mis;
   logic [31:0] a_addr, a_instr, a_pc, a_pc4, a_tgt;
   logic        b_req, b_valid, b_mis;
   logic [31:0] b_addr, b_instr, b_pc, b_pc4, b_tgt;

   fetch_unit #(.RESET_PC(RST_PC_A)) dut_a (
      .clk(clk), .rst(rst), .imem_req(a_req), .imem_addr(a_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .retire(retire), .stall(stall),
      .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult), .instr(a_instr),
      .instr_valid(a_valid), .PC(a_pc), .PCPlus4(a_pc4), .PCTarget(a_tgt),
      .misaligned(a_mis)
   );

   fetch_unit #(.RESET_PC(RST_PC_B)) dut_b (
      .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .retire(retire), .stall(stall),
      .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult), .instr(b_instr),
      .instr_valid(b_valid), .PC(b_pc), .PCPlus4(b_pc4), .PCTarget(b_tgt),
      .misaligned(b_mis)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   // Reference model: what the core has fetched and where it stands, one step at a time.
   logic [31:0] m_pc, m_instr;
   logic        m_valid, m_mis;
   logic        m_ready = 1'b0;

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                              input logic [31:0] imm, input logic [31:0] alu);
      case (src)
         2'b01:   return pc + imm;
         2'b10:   return (alu >> 1) << 1;
         default: return pc + 32'd4;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pc    <= RST_PC_A;
         m_instr <= NOP;
         m_valid <= 1'b0;
         m_mis   <= 1'b0;
         m_ready <= 1'b1;
      end else if (m_ready && !m_mis) begin
         if (!m_valid) begin
            if (imem_ack) begin
               m_instr <= imem_rdata;
               m_valid <= 1'b1;
            end
         end else if (retire && !stall) begin
            m_valid <= 1'b0;
            if (model_next(m_pc, PCSrc, ImmExt, ALUResult) % 32'd4 == 32'd0)
               m_pc <= model_next(m_pc, PCSrc, ImmExt, ALUResult);
            else
               m_mis <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         check_bit("imem_req", a_req, !m_valid && !m_mis && !rst);
         check("imem_addr", a_addr, m_pc);
         check("PC", a_pc, m_pc);
         check("instr", a_instr, m_instr);
         check_bit("instr_valid", a_valid, m_valid);
         check_bit("misaligned", a_mis, m_mis);
         check("PCPlus4", a_pc4, m_pc + 32'd4);
         check("PCTarget", a_tgt, m_pc + ImmExt);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; retire = 1'b0; stall = 1'b0;
      PCSrc = 2'b00; ImmExt = 32'd0; ALUResult = 32'd0;
      cyc(); cyc();

      // First fetch, ack in the first request cycle
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0050_0093; #1;
      check_bit("first_req", a_req, 1'b1);
      check("first_addr", a_addr, 32'h0000_0000);
      check("wrap_reset_addr", b_addr, 32'hFFFF_FFFC);
      check("wrap_pcplus4", b_pc4, 32'h0000_0000);
      cyc(); imem_ack = 1'b0; retire = 1'b1; PCSrc = 2'b00; #1;
      check("first_instr", a_instr, 32'h0050_0093);
      check_bit("first_valid", a_valid, 1'b1);
      check_bit("hold_no_req", a_req, 1'b0);
      cyc(); retire = 1'b0; #1;
      check("pc_after_retire", a_pc, 32'h0000_0004);
      check("model_pc_after_retire", m_pc, 32'h0000_0004);
      check("wrap_pc", b_pc, 32'h0000_0000);

      // Three wait states, ack on the fourth request cycle
      for (int i = 0; i < 3; i++) begin
         check_bit("ws_req", a_req, 1'b1);
         check("ws_addr", a_addr, 32'h0000_0004);
         check_bit("ws_valid", a_valid, 1'b0);
         cyc(); #1;
      end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0013; #1;
      check_bit("ws_req_4th", a_req, 1'b1);
      cyc(); imem_ack = 1'b0; #1;
      check_bit("ws_valid_after_ack", a_valid, 1'b1);

      // JALR to 0x20, then a backwards branch to 0x10
      retire = 1'b1; PCSrc = 2'b10; ALUResult = 32'h0000_0021;
      cyc(); retire = 1'b0; #1;
      check("jalr_pc_20", a_pc, 32'h0000_0020);
      imem_ack = 1'b1; imem_rdata = 32'hFE00_0EE3;
      cyc(); imem_ack = 1'b0; ImmExt = 32'hFFFF_FFF0; PCSrc = 2'b01; retire = 1'b1; #1;
      check("branch_target", a_tgt, 32'h0000_0010);
      cyc(); retire = 1'b0; #1;
      check("branch_addr", a_addr, 32'h0000_0010);
      check_bit("branch_req", a_req, 1'b1);

      // Stall held for two retire cycles, then released
      imem_ack = 1'b1; imem_rdata = 32'h0010_0113;
      cyc(); imem_ack = 1'b0; retire = 1'b1; stall = 1'b1; PCSrc = 2'b00; #1;
      check_bit("stall_valid", a_valid, 1'b1);
      cyc(); #1;
      check("stall1_pc", a_pc, 32'h0000_0010);
      check("stall1_instr", a_instr, 32'h0010_0113);
      cyc(); #1;
      check("stall2_pc", a_pc, 32'h0000_0010);
      check("stall2_instr", a_instr, 32'h0010_0113);
      stall = 1'b0;
      cyc(); retire = 1'b0; #1;
      check("unstall_pc", a_pc, 32'h0000_0014);

      // JALR with odd ALU result lands on 0x200
      imem_ack = 1'b1; imem_rdata = 32'h0000_8067;
      cyc(); imem_ack = 1'b0; retire = 1'b1; PCSrc = 2'b10; ALUResult = 32'h0000_0201;
      cyc(); retire = 1'b0; #1;
      check("jalr_pc_200", a_pc, 32'h0000_0200);

      // Reset in the middle of a waiting fetch
      cyc(); #1;
      check_bit("pre_rst_req", a_req, 1'b1);
      rst = 1'b1; #1;
      check_bit("rst_drops_req", a_req, 1'b0);
      cyc(); rst = 1'b0; #1;
      check_bit("refetch_req", a_req, 1'b1);
      check("refetch_addr", a_addr, 32'h0000_0000);
      check("refetch_instr_nop", a_instr, NOP);
      check("refetch_wrap_addr", b_addr, 32'hFFFF_FFFC);

      // Misaligned JALR target traps; no further requests
      imem_ack = 1'b1; imem_rdata = 32'h0000_8067;
      cyc(); imem_ack = 1'b0; retire = 1'b1; PCSrc = 2'b10; ALUResult = 32'h0000_0102;
      cyc(); retire = 1'b0; #1;
      check_bit("trap_mis", a_mis, 1'b1);
      check_bit("trap_req", a_req, 1'b0);
      check_bit("trap_valid", a_valid, 1'b0);
      check("trap_pc", a_pc, 32'h0000_0000);
      imem_ack = 1'b1; retire = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         check_bit("trap_stays_no_req", a_req, 1'b0);
         check_bit("trap_stays_mis", a_mis, 1'b1);
      end
      imem_ack = 1'b0; retire = 1'b0;

      // 0x103 clears to 0x102, still misaligned
      rst = 1'b1;
      cyc(); rst = 1'b0; #1;
      check_bit("rst_clears_mis", a_mis, 1'b0);
      imem_ack = 1'b1;
      cyc(); imem_ack = 1'b0; retire = 1'b1; PCSrc = 2'b10; ALUResult = 32'h0000_0103;
      cyc(); retire = 1'b0; #1;
      check_bit("trap103_mis", a_mis, 1'b1);
      check("trap103_pc", a_pc, 32'h0000_0000);

      cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
